// File: rtl/reg_file_pair_pkg.sv
// Shared selector/pair codes and the inc/dec sequencer state encoding for
// the CPU register file.
package reg_file_pair_pkg;

    localparam int unsigned REG_B      = 0;
    localparam int unsigned REG_C      = 1;
    localparam int unsigned REG_D      = 2;
    localparam int unsigned REG_E      = 3;
    localparam int unsigned REG_H      = 4;
    localparam int unsigned REG_L      = 5;
    localparam int unsigned REG_HL_IND = 6;
    localparam int unsigned REG_A      = 7;

    localparam int unsigned PAIR_BC = 0;
    localparam int unsigned PAIR_DE = 1;
    localparam int unsigned PAIR_HL = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } incdec_state_e;

endpackage

// File: rtl/reg_file_pair_incdec.sv
// Two-step register-pair increment/decrement sequencer: low byte first, then
// the high byte with the latched carry/borrow, through one shared byte adder.
module reg_pair_incdec
    import reg_file_pair_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PSEL_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                op_valid_i,
    input  logic                op_dec_i,
    input  logic [PSEL_W-1:0]   op_sel_i,
    input  logic [DATA_W-1:0]   rd_data_i,
    output logic                op_ready_o,
    output logic                op_done_o,
    output logic                wr_en_o,
    output logic [PSEL_W:0]     wr_sel_o,
    output logic [DATA_W-1:0]   wr_data_o
);

    incdec_state_e     state_q;
    logic [PSEL_W-1:0] sel_q;
    logic              dec_q;
    logic              carry_q;
    logic              ready_q;
    logic              done_q;

    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   res;

    // Top bit of the widened result is carry-out on inc and borrow on dec.
    always_comb begin
        addend    = '0;
        addend[0] = (state_q == ST_LOW) ? 1'b1 : carry_q;
        if (dec_q) begin
            res = {1'b0, rd_data_i} - {1'b0, addend};
        end else begin
            res = {1'b0, rd_data_i} + {1'b0, addend};
        end
    end

    assign wr_en_o    = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign wr_sel_o   = {sel_q, (state_q == ST_LOW)};
    assign wr_data_o  = res[DATA_W-1:0];
    assign op_ready_o = ready_q;
    assign op_done_o  = done_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            dec_q   <= 1'b0;
            carry_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid_i) begin
                        sel_q   <= op_sel_i;
                        dec_q   <= op_dec_i;
                        ready_q <= 1'b0;
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    carry_q <= res[DATA_W];
                    state_q <= ST_HIGH;
                end
                ST_HIGH: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_file_pair.sv
// CPU register file: two byte read ports, byte and pair write ports, a pair
// read port and the pair inc/dec engine, with optional write-to-read bypass.
module reg_file_pair
    import reg_file_pair_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ZERO_SEL = REG_HL_IND,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [SEL_W-1:0]    out1_sel,
    input  logic [SEL_W-1:0]    out2_sel,
    output logic [DATA_W-1:0]   out1,
    output logic [DATA_W-1:0]   out2,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [SEL_W-1:0]    data_in_sel,
    input  logic                write_reg,
    input  logic [SEL_W-2:0]    pair_sel,
    output logic [2*DATA_W-1:0] pair_out,
    input  logic [2*DATA_W-1:0] pair_in,
    input  logic                write_pair,
    input  logic                op_valid,
    input  logic                op_dec,
    input  logic [SEL_W-2:0]    op_sel,
    output logic                op_ready,
    output logic                op_done
);

    logic [DATA_W-1:0] rf      [NUM_REGS];
    logic              wr_en   [NUM_REGS];
    logic [DATA_W-1:0] wr_data [NUM_REGS];

    logic              eng_we;
    logic [SEL_W-1:0]  eng_sel;
    logic [DATA_W-1:0] eng_wdata;
    logic [DATA_W-1:0] eng_rd;

    logic [SEL_W-1:0]  pair_hi_sel;
    logic [SEL_W-1:0]  pair_lo_sel;

    // Engine operands come from committed storage, never from the bypass path.
    assign eng_rd = rf[eng_sel];

    reg_pair_incdec #(
        .DATA_W (DATA_W),
        .PSEL_W (SEL_W - 1)
    ) u_incdec (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .op_valid_i (op_valid),
        .op_dec_i   (op_dec),
        .op_sel_i   (op_sel),
        .rd_data_i  (eng_rd),
        .op_ready_o (op_ready),
        .op_done_o  (op_done),
        .wr_en_o    (eng_we),
        .wr_sel_o   (eng_sel),
        .wr_data_o  (eng_wdata)
    );

    // Later assignments override earlier ones: engine > pair > byte.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = rf[i];
            if (write_reg && (data_in_sel == SEL_W'(i))) begin
                wr_en[i]   = 1'b1;
                wr_data[i] = data_in;
            end
            if (write_pair && (pair_sel == (SEL_W-1)'(i / 2))) begin
                wr_en[i]   = 1'b1;
                wr_data[i] = ((i % 2) != 0) ? pair_in[DATA_W-1:0]
                                            : pair_in[2*DATA_W-1:DATA_W];
            end
            if (eng_we && (eng_sel == SEL_W'(i))) begin
                wr_en[i]   = 1'b1;
                wr_data[i] = eng_wdata;
            end
            if (i == ZERO_SEL) begin
                wr_en[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == ZERO_SEL) begin : g_zero
            assign rf[g] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] reg_q;
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    reg_q <= '0;
                end else if (wr_en[g]) begin
                    reg_q <= wr_data[g];
                end
            end
            assign rf[g] = reg_q;
        end
    end

    assign pair_hi_sel = {pair_sel, 1'b0};
    assign pair_lo_sel = {pair_sel, 1'b1};

    assign out1 = (BYPASS && wr_en[out1_sel]) ? wr_data[out1_sel] : rf[out1_sel];
    assign out2 = (BYPASS && wr_en[out2_sel]) ? wr_data[out2_sel] : rf[out2_sel];

    assign pair_out[2*DATA_W-1:DATA_W] =
        (BYPASS && wr_en[pair_hi_sel]) ? wr_data[pair_hi_sel] : rf[pair_hi_sel];
    assign pair_out[DATA_W-1:0] =
        (BYPASS && wr_en[pair_lo_sel]) ? wr_data[pair_lo_sel] : rf[pair_lo_sel];

endmodule

// File: tb/tb_reg_file_pair.sv
// Directed bench for reg_file_pair: byte/pair access, zero slot, inc/dec
// engine timing, write priority, bypass and reset abort.
module tb_reg_file_pair;

    logic        clock;
    logic        reset_n;
    logic [2:0]  out1_sel;
    logic [2:0]  out2_sel;
    logic [7:0]  out1;
    logic [7:0]  out2;
    logic [7:0]  data_in;
    logic [2:0]  data_in_sel;
    logic        write_reg;
    logic [1:0]  pair_sel;
    logic [15:0] pair_out;
    logic [15:0] pair_in;
    logic        write_pair;
    logic        op_valid;
    logic        op_dec;
    logic [1:0]  op_sel;
    logic        op_ready;
    logic        op_done;

    int checks = 0;
    int errors = 0;

    reg_file_pair #(
        .DATA_W   (8),
        .NUM_REGS (8),
        .ZERO_SEL (6),
        .BYPASS   (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .out1_sel    (out1_sel),
        .out2_sel    (out2_sel),
        .out1        (out1),
        .out2        (out2),
        .data_in     (data_in),
        .data_in_sel (data_in_sel),
        .write_reg   (write_reg),
        .pair_sel    (pair_sel),
        .pair_out    (pair_out),
        .pair_in     (pair_in),
        .write_pair  (write_pair),
        .op_valid    (op_valid),
        .op_dec      (op_dec),
        .op_sel      (op_sel),
        .op_ready    (op_ready),
        .op_done     (op_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept at N, LOW at N+1, HIGH at N+2; returns inside the op_done cycle.
    task automatic run_op(input logic [1:0] p, input logic dec);
        check("ready_before_op", {15'd0, op_ready}, 16'd1);
        op_sel   = p;
        op_dec   = dec;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        check("done_pulse", {15'd0, op_done}, 16'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        out1_sel    = '0;
        out2_sel    = '0;
        data_in     = '0;
        data_in_sel = '0;
        write_reg   = 1'b0;
        pair_sel    = '0;
        pair_in     = '0;
        write_pair  = 1'b0;
        op_valid    = 1'b0;
        op_dec      = 1'b0;
        op_sel      = '0;
        tick();
        tick();
        reset_n = 1'b1;

        // 1: fill with A5 then reset
        for (int s = 0; s < 8; s++) begin
            data_in_sel = 3'(s);
            data_in     = 8'hA5;
            write_reg   = 1'b1;
            tick();
        end
        write_reg = 1'b0;
        out1_sel  = 3'd7;
        out2_sel  = 3'd6;
        #1;
        check("fill_a", {8'd0, out1}, 16'h00A5);
        check("fill_zero_slot", {8'd0, out2}, 16'h0000);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            out1_sel = 3'(s);
            out2_sel = 3'(7 - s);
            #1;
            check("rst_out1", {8'd0, out1}, 16'h0000);
            check("rst_out2", {8'd0, out2}, 16'h0000);
        end
        for (int p = 0; p < 4; p++) begin
            pair_sel = 2'(p);
            #1;
            check("rst_pair", pair_out, 16'h0000);
        end
        check("rst_ready", {15'd0, op_ready}, 16'd1);
        check("rst_done", {15'd0, op_done}, 16'd0);

        // 2: byte writes, pair read, zero slot
        data_in_sel = 3'd0; data_in = 8'h12; write_reg = 1'b1;
        tick();
        data_in_sel = 3'd1; data_in = 8'h34;
        tick();
        write_reg = 1'b0;
        pair_sel  = 2'd0;
        #1;
        check("pair_bc", pair_out, 16'h1234);
        data_in_sel = 3'd6; data_in = 8'h77; write_reg = 1'b1;
        out1_sel = 3'd6;
        #1;
        check("zero_bypass", {8'd0, out1}, 16'h0000);
        tick();
        write_reg = 1'b0;
        #1;
        check("zero_after", {8'd0, out1}, 16'h0000);
        check("zero_no_side", pair_out, 16'h1234);
        out2_sel = 3'd7;
        #1;
        check("zero_no_side_a", {8'd0, out2}, 16'h0000);

        // 3: inc pair 2 from 00FF, stepwise timing
        pair_sel = 2'd2; pair_in = 16'h00FF; write_pair = 1'b1;
        tick();
        write_pair = 1'b0;
        #1;
        check("hl_set", pair_out, 16'h00FF);
        op_sel = 2'd2; op_dec = 1'b0; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        out1_sel = 3'd5;
        #1;
        check("low_ready", {15'd0, op_ready}, 16'd0);
        check("low_done", {15'd0, op_done}, 16'd0);
        check("low_bypass_pair", pair_out, 16'h0000);
        tick();
        check("high_l_stored", {8'd0, out1}, 16'h0000);
        check("high_ready", {15'd0, op_ready}, 16'd0);
        check("high_done", {15'd0, op_done}, 16'd0);
        check("high_bypass_pair", pair_out, 16'h0100);
        tick();
        check("inc_done", {15'd0, op_done}, 16'd1);
        check("inc_ready", {15'd0, op_ready}, 16'd1);
        check("inc_result", pair_out, 16'h0100);
        tick();
        check("done_one_cycle", {15'd0, op_done}, 16'd0);

        // 4: wrap-around, back-to-back, zero half
        pair_sel = 2'd1; pair_in = 16'h0000; write_pair = 1'b1;
        tick();
        write_pair = 1'b0;
        run_op(2'd1, 1'b1);
        check("dec_wrap", pair_out, 16'hFFFF);
        run_op(2'd1, 1'b0);
        check("inc_wrap", pair_out, 16'h0000);
        tick();
        data_in_sel = 3'd7; data_in = 8'hFF; write_reg = 1'b1;
        tick();
        write_reg = 1'b0;
        pair_sel  = 2'd3;
        run_op(2'd3, 1'b0);
        check("zero_half_inc", pair_out, 16'h0000);
        run_op(2'd3, 1'b1);
        check("zero_half_dec", pair_out, 16'h00FF);
        out1_sel = 3'd6;
        #1;
        check("zero_half_kept", {8'd0, out1}, 16'h0000);
        tick();

        // 5: priority in the LOW cycle, then byte bypass
        pair_sel = 2'd0; pair_in = 16'h1234; write_pair = 1'b1;
        tick();
        write_pair = 1'b0;
        op_sel = 2'd0; op_dec = 1'b0; op_valid = 1'b1;
        tick();
        op_valid    = 1'b0;
        write_reg   = 1'b1; data_in_sel = 3'd1; data_in = 8'h99;
        write_pair  = 1'b1; pair_in = 16'hABCD;
        out2_sel    = 3'd1;
        #1;
        check("prio_low_byp", {8'd0, out2}, 16'h0035);
        check("prio_pair_byp", pair_out, 16'hAB35);
        tick();
        write_reg  = 1'b0;
        write_pair = 1'b0;
        tick();
        check("prio_done", {15'd0, op_done}, 16'd1);
        check("prio_result", pair_out, 16'hAB35);
        tick();
        data_in_sel = 3'd7; data_in = 8'h5A; write_reg = 1'b1;
        out1_sel = 3'd7;
        #1;
        check("bypass_same_cycle", {8'd0, out1}, 16'h005A);
        tick();
        write_reg = 1'b0;
        #1;
        check("bypass_stored", {8'd0, out1}, 16'h005A);

        // 6: reset during HIGH aborts the op
        op_sel = 2'd2; op_dec = 1'b0; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        check("abort_in_high", {15'd0, op_ready}, 16'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_done", {15'd0, op_done}, 16'd0);
        check("abort_ready", {15'd0, op_ready}, 16'd1);
        for (int s = 0; s < 8; s++) begin
            out1_sel = 3'(s);
            #1;
            check("abort_clear", {8'd0, out1}, 16'h0000);
        end
        pair_sel = 2'd2;
        tick();
        check("abort_done_later", {15'd0, op_done}, 16'd0);
        check("abort_no_write", pair_out, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_pair.md
Name: reg_file_pair

Overview:
Parametrised successor to the CPU 8-bit register file. It provides:
- two asynchronous byte read ports and one byte write port;
- a 16-bit register-pair read port and a 16-bit pair write port;
- a multi-cycle pair increment/decrement engine with a valid/ready handshake, for INC rr / DEC rr using an 8-bit adder.
It sits between the decoder/control FSM and the ALU in the CPU core.

Parameters:
DATA_W, 8, width of one register in bits.
NUM_REGS, 8, number of addressable selector codes; must be even and >=4.
ZERO_SEL, 6, selector that reads as zero and drops writes (the (HL) slot); no storage is allocated for it.
BYPASS, 1, 1 = read ports forward the value being written this cycle; 0 = reads show the pre-edge value.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
out1_sel  in  SEL_W=$clog2(NUM_REGS)  read port 1 select
out2_sel  in  SEL_W  read port 2 select
out1  out  DATA_W  read data 1
out2  out  DATA_W  read data 2
data_in  in  DATA_W  byte write data
data_in_sel  in  SEL_W  byte write select
write_reg  in  1  byte write enable
pair_sel  in  SEL_W-1  pair read/write select; pair p = {reg 2p (high), reg 2p+1 (low)}
pair_out  out  2*DATA_W  pair read data
pair_in  in  2*DATA_W  pair write data
write_pair  in  1  pair write enable
op_valid  in  1  pair inc/dec request
op_dec  in  1  0 = increment, 1 = decrement
op_sel  in  SEL_W-1  pair targeted by the op
op_ready  out  1  engine idle; a request is accepted on the edge where op_valid && op_ready
op_done  out  1  one-cycle pulse; high byte written at the preceding edge

Behaviour:
- Reset: when reset_n=0 at a clock edge, all storage is cleared to 0, the FSM goes to IDLE, and op_done=0. After reset, op_ready=1. Reset mid-operation aborts the op and no further writes occur.
- Reads are combinational: outN = reg[outN_sel]; pair_out = {reg[2*pair_sel], reg[2*pair_sel+1]}. Any read of ZERO_SEL returns 0, including one half of a pair.
- Writes take effect at the rising edge. A write to ZERO_SEL is silently dropped, whichever source performs it.
- Write priority per byte in the same cycle, highest first:
  1. engine write;
  2. write_pair;
  3. write_reg.
  Non-conflicting writes to different bytes all commit in the same cycle.
- BYPASS=1: any read whose address matches the winning write this cycle returns the new data. This applies to out1, out2 and each half of pair_out.
- FSM states: IDLE, LOW, HIGH.
  - IDLE: op_ready=1. On op_valid, latch op_sel and op_dec, then go to LOW.
  - LOW: write low byte = low + 1 (inc) or low - 1 (dec), modulo 2^DATA_W. Latch carry (inc: low was all-ones) or borrow (dec: low was 0). Go to HIGH.
  - HIGH: write high byte = high +/- carry. Set op_done=1 for the next cycle. Go to IDLE.
- Latency: request accepted at edge N; low byte written at N+1; high byte written at N+2. op_done is high during the cycle after N+2, and op_ready returns to 1 in that same cycle.
- Back-to-back: a new request is accepted on the edge that ends the op_done cycle, giving a throughput of 1 op per 3 cycles.
- op_valid while op_ready=0 is ignored. The requester holds op_valid until it is accepted.
- Wrap-around: 0xFFFF + 1 = 0x0000 and 0x0000 - 1 = 0xFFFF, with no flag output.
- If the op targets a pair containing ZERO_SEL, the zero half is treated as 0 for the arithmetic and its write is dropped.
- Operand values are read from storage at the LOW and HIGH cycles, not latched at acceptance. External writes to the target pair during LOW therefore affect the HIGH result; avoiding this is the caller's responsibility.

Decomposition:
- Shared package holds:
  - the selector constants REG_B=0, REG_C=1, REG_D=2, REG_E=3, REG_H=4, REG_L=5, REG_HL_IND=6, REG_A=7;
  - the pair constants PAIR_BC=0, PAIR_DE=1, PAIR_HL=2;
  - the FSM state encoding.
- One sub-module, reg_pair_incdec: the LOW/HIGH sequencer with its byte adder and carry latch. It issues a byte write request (enable, select, data) into the storage arbiter.

Test Plan:
1. Reset with every register loaded with 0xA5, then reset_n=0 for one edge -> out1, out2 and pair_out read 0x00/0x0000 for every selector; op_ready=1 and op_done=0.
2. Write 0x12 to sel 0 and 0x34 to sel 1, then read pair 0 -> pair_out=0x1234. Then write 0x77 to sel 6 -> out1_sel=6 reads 0x00 and no other register changes.
3. Set pair 2 to 0x00FF, then inc op -> low=0x00 after edge N+1; pair_out=0x0100 after N+2; op_done pulses for exactly one cycle; op_ready=0 during LOW and HIGH.
4. Set pair 1 to 0x0000, then dec op -> pair becomes 0xFFFF. Set pair 1 to 0xFFFF, then inc op -> pair becomes 0x0000.
5. In the LOW cycle of an op on pair 0, assert write_reg to sel 1 with 0x99 and write_pair to pair 0 -> the engine's low byte wins, the high byte takes the pair_in high half, and the byte write is lost. Separately, with BYPASS=1, write_reg sel 7 = 0x5A with out1_sel=7 -> out1=0x5A in the same cycle.
6. Assert reset_n=0 during HIGH -> op_done stays 0, all registers read 0, and op_ready=1 on the next cycle.
